// File: rtl/jtframe_censched_pkg.sv
// Shared types and helpers for the clock-enable scheduler.
// Holds the pause state machine encoding, reset divider and channel index width.
package jtframe_cen_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        PAUSED
    } cen_st_t;

    localparam int DIV0_DEF = 2;

    // A single-channel build still needs a one-bit channel select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtframe_censched_if.sv
// Bus between the master cen source/config host and the scheduler.
// The master drives enables, config and pause requests; the slave returns strobes and status.
interface jtframe_censched_if import jtframe_cen_pkg::*; #(
    parameter int N  = 4,
    parameter int DW = 8
) ();

    logic                 cen_in;
    logic                 cfg_we;
    logic [ch_w(N)-1:0]   cfg_ch;
    logic [DW-1:0]        cfg_div;
    logic [DW-1:0]        cfg_phase;
    logic [N-1:0]         cfg_pend;
    logic                 sync;
    logic                 pause_req;
    logic                 pause_ack;
    logic [N-1:0]         cen_out;

    modport master (
        output cen_in, cfg_we, cfg_ch, cfg_div, cfg_phase, sync, pause_req,
        input  cfg_pend, pause_ack, cen_out
    );

    modport slave (
        input  cen_in, cfg_we, cfg_ch, cfg_div, cfg_phase, sync, pause_req,
        output cfg_pend, pause_ack, cen_out
    );

endinterface

// File: rtl/jtframe_censched_ch.sv
// One scheduler channel: divider counter, shadowed divide ratio, resync load and strobe.
// New ratios only take effect at a wrap (or immediately when disabled) to avoid runt periods.
module jtframe_censched_ch import jtframe_cen_pkg::*; #(
    parameter int DW   = 8,
    parameter int DIV0 = DIV0_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_i,
    input  logic          active_i,
    input  logic          resync_i,
    input  logic          we_i,
    input  logic [DW-1:0] div_i,
    input  logic [DW-1:0] phase_i,
    output logic          pulse_o,
    output logic          pend_o,
    output logic          div_zero_o
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] phase_q;
    logic [DW-1:0] pdiv_q;
    logic          pend_q;
    logic          div_zero;
    logic          at_wrap;
    logic          apply;

    assign div_zero = (div_q == '0);
    assign at_wrap  = !div_zero && (cnt_q == div_q - DW'(1));
    // A disabled channel never wraps, so it takes new config on any cen.
    assign apply    = cen_i && pend_q && (div_zero || (active_i && at_wrap));
    assign div_d    = apply ? pdiv_q : div_q;

    assign pulse_o    = cen_i && active_i && at_wrap && !resync_i;
    assign pend_o     = pend_q;
    assign div_zero_o = div_zero;

    always_comb begin
        cnt_d = cnt_q;
        if (cen_i) begin
            if (resync_i) begin
                cnt_d = (phase_q < div_d) ? phase_q : '0;
            end else if (apply) begin
                cnt_d = '0;
            end else if (active_i && !div_zero) begin
                cnt_d = at_wrap ? '0 : cnt_q + DW'(1);
            end
        end
    end

    // A write coinciding with an apply keeps the new value pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= DW'(DIV0);
            phase_q <= '0;
            pdiv_q  <= DW'(DIV0);
            pend_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            if (we_i) begin
                pdiv_q  <= div_i;
                phase_q <= phase_i;
                pend_q  <= 1'b1;
            end else if (apply) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jtframe_censched.sv
// Clock-enable scheduler top: N divided strobes from one master cen, with
// resync alignment and a pause handshake that freezes on a channel-0 boundary.
module jtframe_censched import jtframe_cen_pkg::*; #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int DIV0 = DIV0_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    jtframe_censched_if.slave  bus
);

    localparam int           CHW        = ch_w(N);
    localparam logic [N-1:0] DRAIN_MASK = N'(1);

    cen_st_t      state_q;
    logic         sync_pend_q;
    logic         pause_ack_q;
    logic         active;
    logic         resync;
    logic         drain_hit;
    logic [N-1:0] pulse;
    logic [N-1:0] pend;
    logic [N-1:0] div_zero;

    assign active = (state_q != PAUSED);
    assign resync = bus.cen_in && (sync_pend_q || bus.sync);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            jtframe_censched_ch #(
                .DW   (DW),
                .DIV0 (DIV0)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .cen_i      (bus.cen_in),
                .active_i   (active),
                .resync_i   (resync),
                .we_i       (bus.cfg_we && (bus.cfg_ch == CHW'(i))),
                .div_i      (bus.cfg_div),
                .phase_i    (bus.cfg_phase),
                .pulse_o    (pulse[i]),
                .pend_o     (pend[i]),
                .div_zero_o (div_zero[i])
            );
        end
    endgenerate

    // Channel 0 paces the drain: freeze on its strobe, or at once if it is disabled.
    assign drain_hit = bus.cen_in && (|((pulse | div_zero) & DRAIN_MASK));

    assign bus.cen_out   = pulse;
    assign bus.cfg_pend  = pend;
    assign bus.pause_ack = pause_ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_pend_q <= 1'b0;
        end else if (bus.cen_in) begin
            sync_pend_q <= 1'b0;
        end else if (bus.sync) begin
            sync_pend_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pause_ack_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.pause_req) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!bus.pause_req) begin
                        state_q <= RUN;
                    end else if (drain_hit) begin
                        state_q     <= PAUSED;
                        pause_ack_q <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (!bus.pause_req) begin
                        state_q     <= RUN;
                        pause_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= RUN;
                    pause_ack_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_censched.sv
// Bench for jtframe_censched: a hand-derived vector table for reset and reconfiguration,
// then scenario and random sequences checked against a behavioural scoreboard model.
module tb_jtframe_censched;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CHW = 2;

    typedef struct {
        bit cen;
        bit we;
        int ch;
        int div;
        int phase;
        bit sync;
        bit preq;
    } stim_t;

    typedef struct {
        stim_t        s;
        logic [N-1:0] expCen;
        logic [N-1:0] expPend;
        bit           expAck;
    } vec_t;

    typedef struct {
        logic [N-1:0] cen;
        logic [N-1:0] pend;
        bit           ack;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t expQ[$];

    int mCnt[N];
    int mDiv[N];
    int mPhase[N];
    int mPdiv[N];
    bit mPend[N];
    int mState;
    bit mSyncP;
    bit mAck;

    jtframe_censched_if #(.N(N), .DW(DW)) bus ();

    jtframe_censched #(.N(N), .DW(DW), .DIV0(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t mkStim(bit cen, bit we, int ch, int div, int phase, bit sync, bit preq);
        stim_t s;
        s.cen = cen; s.we = we; s.ch = ch; s.div = div;
        s.phase = phase; s.sync = sync; s.preq = preq;
        return s;
    endfunction

    function automatic vec_t mkVec(stim_t s, logic [N-1:0] c, logic [N-1:0] p, bit a);
        vec_t v;
        v.s = s; v.expCen = c; v.expPend = p; v.expAck = a;
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mCnt[i] = 0; mDiv[i] = 2; mPhase[i] = 0; mPdiv[i] = 2; mPend[i] = 0;
        end
        mState = 0; mSyncP = 0; mAck = 0;
    endtask

    function automatic bit mWrap(int i);
        return (mDiv[i] != 0) && (mCnt[i] == mDiv[i] - 1);
    endfunction

    function automatic exp_t modelOut(stim_t s, string tag);
        exp_t e;
        bit syncNow = mSyncP || s.sync;
        for (int i = 0; i < N; i++) begin
            e.cen[i]  = s.cen && (mState != 2) && mWrap(i) && !syncNow;
            e.pend[i] = mPend[i];
        end
        e.ack = mAck;
        e.tag = tag;
        return e;
    endfunction

    task automatic modelStep(stim_t s);
        bit syncNow = mSyncP || s.sync;
        bit active  = (mState != 2);
        bit ch0Hit  = s.cen && ((active && mWrap(0) && !syncNow) || mDiv[0] == 0);
        for (int i = 0; i < N; i++) begin
            bit wrap  = mWrap(i);
            bit apply = s.cen && mPend[i] && (mDiv[i] == 0 || (active && wrap));
            int nDiv  = apply ? mPdiv[i] : mDiv[i];
            if (s.cen) begin
                if (syncNow)                    mCnt[i] = (mPhase[i] < nDiv) ? mPhase[i] : 0;
                else if (apply)                 mCnt[i] = 0;
                else if (active && mDiv[i] != 0) mCnt[i] = wrap ? 0 : mCnt[i] + 1;
            end
            if (s.we && s.ch == i) begin
                mPdiv[i] = s.div; mPhase[i] = s.phase; mPend[i] = 1;
            end else if (apply) begin
                mPend[i] = 0;
            end
            mDiv[i] = nDiv;
        end
        case (mState)
            0: if (s.preq) mState = 1;
            1: if (!s.preq) mState = 0;
               else if (ch0Hit) begin mState = 2; mAck = 1; end
            default: if (!s.preq) begin mState = 0; mAck = 0; end
        endcase
        if (s.cen) mSyncP = 0;
        else if (s.sync) mSyncP = 1;
    endtask

    task automatic driveInputs(stim_t s);
        bus.cen_in    = s.cen;
        bus.cfg_we    = s.we;
        bus.cfg_ch    = CHW'(s.ch);
        bus.cfg_div   = DW'(s.div);
        bus.cfg_phase = DW'(s.phase);
        bus.sync      = s.sync;
        bus.pause_req = s.preq;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            compared++; mismatched++;
            $display("[TB] FAIL scoreboard underflow");
            return;
        end
        e = expQ.pop_front();
        compared++;
        if (bus.cen_out !== e.cen) begin
            mismatched++;
            $display("[TB] FAIL %s cen_out got %b want %b", e.tag, bus.cen_out, e.cen);
        end
        compared++;
        if (bus.cfg_pend !== e.pend) begin
            mismatched++;
            $display("[TB] FAIL %s cfg_pend got %b want %b", e.tag, bus.cfg_pend, e.pend);
        end
        compared++;
        if (bus.pause_ack !== e.ack) begin
            mismatched++;
            $display("[TB] FAIL %s pause_ack got %b want %b", e.tag, bus.pause_ack, e.ack);
        end
    endtask

    // One clock: drive just after posedge, compare at negedge, advance model after next posedge.
    task automatic runCycle(stim_t s, exp_t e);
        driveInputs(s);
        expQ.push_back(e);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        modelStep(s);
    endtask

    task automatic applyStimulus(stim_t s, string tag);
        runCycle(s, modelOut(s, tag));
    endtask

    task automatic applyVector(vec_t v, int idx);
        exp_t e;
        e.cen = v.expCen; e.pend = v.expPend; e.ack = v.expAck;
        e.tag = $sformatf("vec%0d", idx);
        runCycle(v.s, e);
    endtask

    task automatic idleCens(int n, bit preq, string tag);
        for (int k = 0; k < n; k++) applyStimulus(mkStim(1, 0, 0, 0, 0, 0, preq), tag);
    endtask

    vec_t table_v[16];

    initial begin
        stim_t s;
        bit    pausedSeen;

        driveInputs(mkStim(0, 0, 0, 0, 0, 0, 0));
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Defaults divide by 2, then channel 1 is retimed to 3 and later to 5.
        table_v[0]  = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b0000, 4'b0000, 0);
        table_v[1]  = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b1111, 4'b0000, 0);
        table_v[2]  = mkVec(mkStim(0, 0, 0, 0, 0, 0, 0), 4'b0000, 4'b0000, 0);
        table_v[3]  = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b0000, 4'b0000, 0);
        table_v[4]  = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b1111, 4'b0000, 0);
        table_v[5]  = mkVec(mkStim(0, 1, 1, 3, 0, 0, 0), 4'b0000, 4'b0000, 0);
        table_v[6]  = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b0000, 4'b0010, 0);
        table_v[7]  = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b1111, 4'b0010, 0);
        table_v[8]  = mkVec(mkStim(1, 1, 1, 5, 0, 0, 0), 4'b0000, 4'b0000, 0);
        table_v[9]  = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b1101, 4'b0010, 0);
        table_v[10] = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b0010, 4'b0010, 0);
        table_v[11] = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b1101, 4'b0000, 0);
        table_v[12] = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b0000, 4'b0000, 0);
        table_v[13] = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b1101, 4'b0000, 0);
        table_v[14] = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b0000, 4'b0000, 0);
        table_v[15] = mkVec(mkStim(1, 0, 0, 0, 0, 0, 0), 4'b1111, 4'b0000, 0);
        for (int k = 0; k < 16; k++) applyVector(table_v[k], k);

        $display("[TB] disable and re-enable channel 2");
        applyStimulus(mkStim(0, 1, 2, 0, 0, 0, 0), "dis_wr");
        idleCens(5, 0, "dis_run");
        applyStimulus(mkStim(0, 1, 2, 4, 0, 0, 0), "en_wr");
        idleCens(8, 0, "en_run");

        $display("[TB] resync with phases 0,1,2,7");
        for (int i = 0; i < N; i++) begin
            int ph = (i == 3) ? 7 : i;
            applyStimulus(mkStim(0, 1, i, 4, ph, 0, 0), "rs_wr");
        end
        idleCens(12, 0, "rs_apply");
        applyStimulus(mkStim(0, 0, 0, 0, 0, 1, 0), "rs_sync");
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0), "rs_gap");
        idleCens(6, 0, "rs_run");
        applyStimulus(mkStim(1, 0, 0, 0, 0, 1, 0), "rs_cosync");
        idleCens(4, 0, "rs_run2");

        $display("[TB] pause handshake on channel 0 div 6");
        applyStimulus(mkStim(0, 1, 0, 6, 0, 0, 0), "pz_wr");
        idleCens(8, 0, "pz_apply");
        while (mCnt[0] != 2) applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0), "pz_align");
        idleCens(8, 1, "pz_drain");
        applyStimulus(mkStim(0, 1, 3, 0, 0, 0, 1), "pz_cfg");
        idleCens(3, 1, "pz_hold");
        idleCens(10, 0, "pz_resume");

        $display("[TB] drop pause_req during drain");
        while (mCnt[0] != 1) applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 0), "dr_align");
        idleCens(2, 1, "dr_req");
        idleCens(8, 0, "dr_run");

        $display("[TB] random traffic");
        s = mkStim(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            s.cen   = ($urandom_range(3) != 0);
            s.we    = ($urandom_range(9) == 0);
            s.ch    = $urandom_range(N - 1);
            s.div   = $urandom_range(6);
            s.phase = $urandom_range(7);
            s.sync  = ($urandom_range(19) == 0);
            if ($urandom_range(15) == 0) s.preq = !s.preq;
            applyStimulus(s, "rnd");
        end

        $display("[TB] reset while paused");
        applyStimulus(mkStim(0, 1, 0, 3, 0, 0, 0), "rp_wr");
        idleCens(6, 0, "rp_apply");
        pausedSeen = 0;
        for (int k = 0; k < 64 && !pausedSeen; k++) begin
            applyStimulus(mkStim(1, 0, 0, 0, 0, 0, 1), "rp_drain");
            pausedSeen = (mState == 2);
        end
        compared++;
        if (!pausedSeen) begin
            mismatched++;
            $display("[TB] FAIL rp_reach paused got 0 want 1");
        end
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1), "rp_paused");
        rst_n = 1'b0;
        bus.pause_req = 1'b0;
        #1;
        compared++;
        if (bus.pause_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rp_async pause_ack got %b want 0", bus.pause_ack);
        end
        compared++;
        if (bus.cfg_pend !== '0) begin
            mismatched++;
            $display("[TB] FAIL rp_async cfg_pend got %b want 0000", bus.cfg_pend);
        end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idleCens(8, 0, "rp_defaults");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
